// File: rtl/f_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// f_fetch_ctrl_if
//
// Interface bundling every signal exchanged between the fetch sequencer and
// its neighbours: the IFU (PC register plus instruction ROM), the
// redirect/branch source, the decode stage and the fault reporting path.
//
//   master : the fetch sequencer (f_fetch_ctrl)
//   slave  : the surrounding pipeline / environment
//
// Signals
//   ifu_pc          IFU -> ctrl   current PC register value
//   ifu_instr       IFU -> ctrl   ROM word at ifu_pc (combinational read)
//   ifu_pc_wr_en    ctrl -> IFU   PC loads ifu_npc on the next posedge
//   ifu_npc         ctrl -> IFU   next PC
//   redirect_valid  src -> ctrl   redirect request (pulse or held)
//   redirect_target src -> ctrl   redirect destination
//   d_valid         ctrl -> dec   head entry available
//   d_ready         dec -> ctrl   decode takes the head entry
//   d_pc, d_instr   ctrl -> dec   head entry contents
//   fetch_fault     ctrl -> sys   sticky illegal-PC flag
//   fault_pc        ctrl -> sys   offending PC
//   q_count         ctrl -> sys   FIFO occupancy
// ---------------------------------------------------------------------------
interface f_fetch_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      ifu_pc;
    logic [31:0]      ifu_instr;
    logic             ifu_pc_wr_en;
    logic [31:0]      ifu_npc;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic             d_valid;
    logic             d_ready;
    logic [31:0]      d_pc;
    logic [31:0]      d_instr;
    logic             fetch_fault;
    logic [31:0]      fault_pc;
    logic [CNT_W-1:0] q_count;

    modport master (
        input  ifu_pc, ifu_instr, redirect_valid, redirect_target, d_ready,
        output ifu_pc_wr_en, ifu_npc, d_valid, d_pc, d_instr,
               fetch_fault, fault_pc, q_count
    );

    modport slave (
        output ifu_pc, ifu_instr, redirect_valid, redirect_target, d_ready,
        input  ifu_pc_wr_en, ifu_npc, d_valid, d_pc, d_instr,
               fetch_fault, fault_pc, q_count
    );
endinterface

// File: rtl/f_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// f_fetch_ctrl
//
// Fetch-stage sequencer between the IFU and decode. Each cycle it may fetch
// one {PC, instruction} pair from the IFU into a small circular FIFO and
// advance the PC by 4; decode drains the FIFO through a valid/ready
// handshake. Redirects flush the FIFO and reload the PC; a fetch from an
// illegal PC (misaligned or outside the ROM window) freezes fetching and
// raises a sticky fault until the next redirect or reset.
//
// Ports
//   clk    system clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    f_fetch_ctrl_if.master (IFU, redirect, decode and fault signals)
//
// Parameters
//   DEPTH      FIFO entries, power of two in 2..16
//   ROM_BASE   first legal fetch address (also the IFU reset PC)
//   ROM_WORDS  number of legal instruction words from ROM_BASE
// ---------------------------------------------------------------------------
module f_fetch_ctrl #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] ROM_BASE  = 32'h0000_3000,
    parameter int          ROM_WORDS = 4096
) (
    input  logic           clk,
    input  logic           reset,
    f_fetch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Legal window bounds held in 33 bits so ROM_BASE + 4*ROM_WORDS never
    // wraps, even for a ROM ending exactly at the top of the address space.
    localparam logic [32:0] ROM_LO = {1'b0, ROM_BASE};
    localparam logic [32:0] ROM_HI = ROM_LO + (33'(ROM_WORDS) << 2);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fault_r;
    logic [31:0]       fault_pc_r;

    logic [31:0]       pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];

    logic              d_valid_c;
    logic              pop;
    logic              push;
    logic              illegal;
    logic              space;
    logic              fire;
    logic [32:0]       pc_ext;

    // ------------------------------------------------------------------
    // Combinational control terms
    // ------------------------------------------------------------------
    assign pc_ext  = {1'b0, bus.ifu_pc};
    assign illegal = (bus.ifu_pc[1:0] != 2'b00) |
                     (pc_ext < ROM_LO) |
                     (pc_ext >= ROM_HI);

    // A pending redirect hides the head entry so nothing is popped in the
    // cycle the FIFO is being flushed.
    assign d_valid_c = (count != '0) & ~bus.redirect_valid & ~reset;
    assign pop       = d_valid_c & bus.d_ready;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    // a push and sustain one instruction per cycle.
    assign space = (count < CNT_W'(DEPTH)) | pop;
    assign fire  = (state == RUN) & ~bus.redirect_valid & ~illegal & space;
    assign push  = fire & ~reset;

    assign bus.ifu_pc_wr_en = ~reset & (bus.redirect_valid | fire);
    assign bus.ifu_npc      = bus.redirect_valid ? bus.redirect_target
                                                 : (bus.ifu_pc + 32'd4);

    assign bus.d_valid     = d_valid_c;
    assign bus.d_pc        = pc_mem[rd_ptr];
    assign bus.d_instr     = instr_mem[rd_ptr];
    assign bus.fetch_fault = fault_r;
    assign bus.fault_pc    = fault_pc_r;
    assign bus.q_count     = count;

    // ------------------------------------------------------------------
    // Control state: FSM, fault flag, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            fault_r    <= 1'b0;
            fault_pc_r <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else if (bus.redirect_valid) begin
            // Flush and restart; fault_pc keeps its last value but is only
            // meaningful while fetch_fault is set.
            state   <= RUN;
            fault_r <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if ((state == RUN) && illegal) begin
                state      <= FAULT;
                fault_r    <= 1'b1;
                fault_pc_r <= bus.ifu_pc;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (data only, no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.ifu_pc;
            instr_mem[wr_ptr] <= bus.ifu_instr;
        end
    end
endmodule

// File: tb/tb_f_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_f_fetch_ctrl
//
// Bench for f_fetch_ctrl with a behavioural IFU (PC register reset to
// ROM_BASE plus a combinational ROM whose word is a fixed function of the
// address). A table of per-cycle vectors drives reset/redirect/d_ready and
// holds the hand-computed observable state for that cycle; a few
// hand-written sequences follow for ROM-boundary faults and held redirects.
// ---------------------------------------------------------------------------
module tb_f_fetch_ctrl;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] ROM_BASE  = 32'h0000_3000;
    localparam int          ROM_WORDS = 4096;

    logic        clk;
    logic        reset;
    logic [31:0] pc_r;

    int checks = 0;
    int errors = 0;

    f_fetch_ctrl_if #(.DEPTH(DEPTH)) bus ();

    f_fetch_ctrl #(
        .DEPTH    (DEPTH),
        .ROM_BASE (ROM_BASE),
        .ROM_WORDS(ROM_WORDS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    // IFU model
    always_ff @(posedge clk) begin
        if (reset) pc_r <= ROM_BASE;
        else if (bus.ifu_pc_wr_en) pc_r <= bus.ifu_npc;
    end
    assign bus.ifu_pc    = pc_r;
    assign bus.ifu_instr = rom(pc_r);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rt;
        logic        rdy;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic [31:0] e_cnt;
        logic [31:0] e_ipc;
        logic        e_wr;
        logic        e_flt;
        logic        chk_fpc;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rv, input logic [31:0] rt,
                       input logic rdy, input logic dv, input logic [31:0] dpc,
                       input logic [31:0] cnt, input logic [31:0] ipc,
                       input logic wr, input logic flt, input logic cf,
                       input logic [31:0] fpc);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rt = rt; v.rdy = rdy;
        v.e_dv = dv; v.e_dpc = dpc; v.e_cnt = cnt; v.e_ipc = ipc;
        v.e_wr = wr; v.e_flt = flt; v.chk_fpc = cf; v.e_fpc = fpc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive on the falling edge, observe 1 time unit later.
    task automatic cyc(input logic rst, input logic rv, input logic [31:0] rt,
                       input logic rdy);
        @(negedge clk);
        reset               = rst;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.d_ready         = rdy;
        #1;
    endtask

    initial begin
        reset               = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.d_ready         = 1'b0;

        // rst rv  rt        rdy dv dpc       cnt ipc       wr flt cf fpc
        // reset observed
        add(1, 0, 0,        1,  0, 0,        0, 32'h3000, 0, 0, 1, 0);
        // straight-line fetch
        add(0, 0, 0,        1,  0, 0,        0, 32'h3000, 1, 0, 0, 0);
        add(0, 0, 0,        1,  1, 32'h3000, 1, 32'h3004, 1, 0, 0, 0);
        add(0, 0, 0,        1,  1, 32'h3004, 1, 32'h3008, 1, 0, 0, 0);
        add(0, 0, 0,        1,  1, 32'h3008, 1, 32'h300C, 1, 0, 0, 0);
        add(0, 0, 0,        1,  1, 32'h300C, 1, 32'h3010, 1, 0, 0, 0);
        add(0, 0, 0,        1,  1, 32'h3010, 1, 32'h3014, 1, 0, 0, 0);
        // reset with one entry queued
        add(1, 0, 0,        1,  0, 0,        1, 32'h3018, 0, 0, 0, 0);
        // decode stall: 8 cycles of d_ready=0
        add(0, 0, 0,        0,  0, 0,        0, 32'h3000, 1, 0, 0, 0);
        add(0, 0, 0,        0,  1, 32'h3000, 1, 32'h3004, 1, 0, 0, 0);
        add(0, 0, 0,        0,  1, 32'h3000, 2, 32'h3008, 1, 0, 0, 0);
        add(0, 0, 0,        0,  1, 32'h3000, 3, 32'h300C, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0,    0,  1, 32'h3000, 4, 32'h3010, 0, 0, 0, 0);
        // release: full FIFO with push+pop every cycle across pointer wrap
        add(0, 0, 0,        1,  1, 32'h3000, 4, 32'h3010, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++)
            add(0, 0, 0,    1,  1, 32'h3004 + 32'(4 * k), 4,
                32'h3014 + 32'(4 * k), 1, 0, 0, 0);
        // redirect while full
        add(0, 1, 32'h3100, 1,  0, 0,        4, 32'h303C, 1, 0, 0, 0);
        add(0, 0, 0,        1,  0, 0,        0, 32'h3100, 1, 0, 0, 0);
        add(0, 0, 0,        1,  1, 32'h3100, 1, 32'h3104, 1, 0, 0, 0);
        // misaligned PC
        add(0, 1, 32'h3102, 1,  0, 0,        1, 32'h3108, 1, 0, 0, 0);
        add(0, 0, 0,        1,  0, 0,        0, 32'h3102, 0, 0, 0, 0);
        add(0, 0, 0,        1,  0, 0,        0, 32'h3102, 0, 1, 1, 32'h3102);
        add(0, 0, 0,        1,  0, 0,        0, 32'h3102, 0, 1, 1, 32'h3102);
        // beyond ROM
        add(0, 1, 32'h7000, 1,  0, 0,        0, 32'h3102, 1, 1, 1, 32'h3102);
        add(0, 0, 0,        1,  0, 0,        0, 32'h7000, 0, 0, 0, 0);
        add(0, 0, 0,        1,  0, 0,        0, 32'h7000, 0, 1, 1, 32'h7000);
        // recover at ROM_BASE
        add(0, 1, 32'h3000, 1,  0, 0,        0, 32'h7000, 1, 1, 1, 32'h7000);
        add(0, 0, 0,        1,  0, 0,        0, 32'h3000, 1, 0, 0, 0);
        add(0, 0, 0,        1,  1, 32'h3000, 1, 32'h3004, 1, 0, 0, 0);
        // build to 3 entries, then reset together with a redirect
        add(0, 0, 0,        0,  1, 32'h3004, 1, 32'h3008, 1, 0, 0, 0);
        add(0, 0, 0,        0,  1, 32'h3004, 2, 32'h300C, 1, 0, 0, 0);
        add(1, 1, 32'h3100, 1,  0, 0,        3, 32'h3010, 0, 0, 0, 0);
        add(0, 0, 0,        1,  0, 0,        0, 32'h3000, 1, 0, 1, 0);

        // initial reset, unchecked
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].rv, vecs[i].rt, vecs[i].rdy);
            chk($sformatf("v%0d d_valid", i), 32'(bus.d_valid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d q_count", i), 32'(bus.q_count), vecs[i].e_cnt);
            chk($sformatf("v%0d ifu_pc", i), bus.ifu_pc, vecs[i].e_ipc);
            chk($sformatf("v%0d ifu_pc_wr_en", i), 32'(bus.ifu_pc_wr_en), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d fetch_fault", i), 32'(bus.fetch_fault), 32'(vecs[i].e_flt));
            if (vecs[i].chk_fpc)
                chk($sformatf("v%0d fault_pc", i), bus.fault_pc, vecs[i].e_fpc);
            if (vecs[i].e_dv) begin
                chk($sformatf("v%0d d_pc", i), bus.d_pc, vecs[i].e_dpc);
                chk($sformatf("v%0d d_instr", i), bus.d_instr, rom(vecs[i].e_dpc));
            end
        end

        // Last legal word, then fault on the first word past the ROM while
        // the queued last word still drains.
        cyc(0, 1, 32'h6FFC, 0);
        chk("h1 wr_en", 32'(bus.ifu_pc_wr_en), 32'd1);
        chk("h1 npc", bus.ifu_npc, 32'h6FFC);
        cyc(0, 0, 0, 0);
        chk("h2 ifu_pc", bus.ifu_pc, 32'h6FFC);
        chk("h2 wr_en", 32'(bus.ifu_pc_wr_en), 32'd1);
        chk("h2 q_count", 32'(bus.q_count), 32'd0);
        cyc(0, 0, 0, 0);
        chk("h3 ifu_pc", bus.ifu_pc, 32'h7000);
        chk("h3 wr_en", 32'(bus.ifu_pc_wr_en), 32'd0);
        chk("h3 q_count", 32'(bus.q_count), 32'd1);
        chk("h3 d_pc", bus.d_pc, 32'h6FFC);
        chk("h3 fetch_fault", 32'(bus.fetch_fault), 32'd0);
        cyc(0, 0, 0, 1);
        chk("h4 fetch_fault", 32'(bus.fetch_fault), 32'd1);
        chk("h4 fault_pc", bus.fault_pc, 32'h7000);
        chk("h4 d_valid", 32'(bus.d_valid), 32'd1);
        chk("h4 d_instr", bus.d_instr, rom(32'h6FFC));
        chk("h4 wr_en", 32'(bus.ifu_pc_wr_en), 32'd0);
        cyc(0, 0, 0, 1);
        chk("h5 q_count", 32'(bus.q_count), 32'd0);
        chk("h5 d_valid", 32'(bus.d_valid), 32'd0);
        chk("h5 fetch_fault", 32'(bus.fetch_fault), 32'd1);

        // Just below ROM_BASE
        cyc(0, 1, 32'h2FFC, 1);
        chk("h6 wr_en", 32'(bus.ifu_pc_wr_en), 32'd1);
        cyc(0, 0, 0, 1);
        chk("h7 wr_en", 32'(bus.ifu_pc_wr_en), 32'd0);
        chk("h7 fetch_fault", 32'(bus.fetch_fault), 32'd0);
        cyc(0, 0, 0, 1);
        chk("h8 fetch_fault", 32'(bus.fetch_fault), 32'd1);
        chk("h8 fault_pc", bus.fault_pc, 32'h2FFC);

        // Held redirect keeps reloading and keeps the FIFO empty
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'h3200, 1);
            chk($sformatf("held%0d wr_en", i), 32'(bus.ifu_pc_wr_en), 32'd1);
            chk($sformatf("held%0d npc", i), bus.ifu_npc, 32'h3200);
            chk($sformatf("held%0d d_valid", i), 32'(bus.d_valid), 32'd0);
            if (i > 0) begin
                chk($sformatf("held%0d ifu_pc", i), bus.ifu_pc, 32'h3200);
                chk($sformatf("held%0d q_count", i), 32'(bus.q_count), 32'd0);
                chk($sformatf("held%0d fetch_fault", i), 32'(bus.fetch_fault), 32'd0);
            end
        end
        cyc(0, 0, 0, 1);
        chk("h12 wr_en", 32'(bus.ifu_pc_wr_en), 32'd1);
        chk("h12 npc", bus.ifu_npc, 32'h3204);
        cyc(0, 0, 0, 1);
        chk("h13 d_valid", 32'(bus.d_valid), 32'd1);
        chk("h13 d_pc", bus.d_pc, 32'h3200);
        chk("h13 ifu_pc", bus.ifu_pc, 32'h3204);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/f_fetch_ctrl.md
Name: f_fetch_ctrl

Overview:
- Fetch-stage sequencer sitting between the instruction fetch unit (PC register plus instruction ROM) and the decode stage.
- Drives the IFU's PC write enable and next-PC.
- Buffers fetched {PC, instruction} pairs in a small FIFO toward decode using a valid/ready handshake.
- Handles control-flow redirects (flush plus reload) and traps fetches from illegal PCs.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ROM_BASE, 32'h0000_3000, first legal fetch address; also the IFU reset PC.
- ROM_WORDS, 4096, number of legal instruction words starting at ROM_BASE.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ifu_pc  in  32  current IFU PC register value.
- ifu_instr  in  32  instruction read combinationally from the ROM at ifu_pc.
- ifu_pc_wr_en  out  1  IFU PC write enable; the PC loads ifu_npc on the next posedge.
- ifu_npc  out  32  next PC presented to the IFU.
- redirect_valid  in  1  branch/jump redirect request; single-cycle pulse or held.
- redirect_target  in  32  redirect destination PC.
- d_valid  out  1  head FIFO entry is available to decode.
- d_ready  in  1  decode accepts the head entry this cycle.
- d_pc  out  32  PC of the head entry.
- d_instr  out  32  instruction of the head entry.
- fetch_fault  out  1  sticky flag: fetch stopped on an illegal PC.
- fault_pc  out  32  the offending PC, valid while fetch_fault=1.
- q_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=1 at posedge):
  - q_count=0, d_valid=0, fetch_fault=0, fault_pc=0, state=RUN.
  - ifu_pc_wr_en is forced 0 combinationally while reset=1; the IFU resets itself to ROM_BASE.
- States:
  - RUN: normal fetch.
  - FAULT: fetch frozen.
- Combinational terms:
  - pop = d_valid & d_ready.
  - d_valid = (q_count!=0) & ~redirect_valid & ~reset.
  - illegal = (ifu_pc[1:0]!=0) | (ifu_pc<ROM_BASE) | (ifu_pc>=ROM_BASE+4*ROM_WORDS); compare in 33 bits, no wrap.
  - space = (q_count<DEPTH) | pop.
  - fire = (state==RUN) & ~redirect_valid & ~illegal & space.
- Priority, highest first:
  1. reset
  2. redirect
  3. fault detection
  4. fetch/pop
- Redirect (redirect_valid=1, reset=0):
  - ifu_pc_wr_en=1, ifu_npc=redirect_target.
  - At the posedge: FIFO flushed (q_count:=0, pointers:=0); no push and no pop that cycle; state:=RUN; fetch_fault:=0.
  - A held redirect reloads the same target every cycle and keeps the FIFO empty.
- Fault (state==RUN, no redirect, illegal=1):
  - ifu_pc_wr_en=0, no push.
  - At the posedge: state:=FAULT, fetch_fault:=1, fault_pc:=ifu_pc.
  - Entries already queued still drain to decode normally.
- FAULT state:
  - ifu_pc_wr_en=0; pops are still allowed.
  - Exits only on redirect or reset.
- Fetch:
  - When fire=1: ifu_pc_wr_en=1, ifu_npc=ifu_pc+4 (mod 2^32), and {ifu_pc, ifu_instr} is pushed at the posedge.
  - Otherwise ifu_pc_wr_en=0 and ifu_npc=ifu_pc+4 (don't-care).
- FIFO:
  - Circular buffer; pointers wrap at DEPTH.
  - Simultaneous push and pop when full is legal: occupancy stays DEPTH and order is preserved.
  - Push into empty: the entry is visible on d_pc/d_instr the cycle after the push (one-cycle fetch-to-decode latency).
  - d_pc/d_instr are don't-care when d_valid=0.
  - Throughput: one instruction per cycle sustained when d_ready=1.
- Decode stall (d_ready=0): the FIFO fills to DEPTH, then fire=0, so the PC holds and no instruction is lost or duplicated.
- Mid-operation reset overrides any redirect, fault, or pop in the same cycle.

Test Plan:
- Straight-line fetch:
  - Stimulus: reset, release, d_ready=1 for 6 cycles.
  - Required: d_pc = 3000, 3004, 3008... on consecutive cycles from cycle 1; d_instr matches the ROM words; q_count ≤ 1.
- Decode stall:
  - Stimulus: d_ready=0 for 8 cycles, then 1.
  - Required: q_count saturates at 4; ifu_pc holds at 0x3010 with ifu_pc_wr_en=0; after release, 3000, 3004, 3008, 300C, 3010 are delivered with no gap or duplicate.
- Redirect while full:
  - Stimulus: queue at 4, redirect_valid pulse with target 0x3100 and d_ready=1 in the same cycle.
  - Required: d_valid=0 that cycle, no pop; next cycle q_count=0 and ifu_pc=0x3100; the following cycle d_pc=0x3100.
- Illegal PC:
  - Stimulus: redirect to 0x3102.
  - Required: the next cycle sets fetch_fault=1 and fault_pc=0x3102; no push; ifu_pc_wr_en stays 0.
  - Stimulus: redirect to 0x7000 (beyond ROM).
  - Required: same fault behaviour.
  - Stimulus: redirect to 0x3000.
  - Required: fetch_fault clears; fetch resumes at 0x3000.
- Simultaneous push/pop when full:
  - Stimulus: q_count=4, d_ready=1 continuously.
  - Required: q_count stays 4; order preserved across pointer wrap for 10+ cycles.
- Reset mid-stream:
  - Stimulus: assert reset with q_count=3 and redirect_valid=1.
  - Required: next cycle q_count=0, d_valid=0, fetch_fault=0, ifu_pc=0x3000; ifu_pc_wr_en=0 during reset.
